// File: rtl/pmp_check_arbiter.sv
// pmp_check_arbiter: shares one PMP checker between the ifetch and data
// requesters. At most one check is issued per cycle and its result comes back
// one cycle later, routed to the source that issued it. CSR writes to
// pmpcfg/pmpaddr are sequenced so that they never overlap an in-flight check.
module pmp_check_arbiter #(
  parameter int pmp_msb    = 55,
  parameter int starve_max = 4
) (
  input  logic             clk300p,
  input  logic             rst,
  input  logic             i_req,
  input  logic [pmp_msb:0] i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic             i_ok,
  input  logic             d_req,
  input  logic [pmp_msb:0] d_addr,
  input  logic [1:0]       d_acc,
  input  logic [1:0]       d_size,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic             d_ok,
  input  logic [1:0]       prv,
  input  logic             mprv,
  input  logic [1:0]       mpp,
  output logic             pmp_valid,
  output logic [pmp_msb:0] pmp_address,
  output logic [1:0]       pmp_acc,
  output logic [1:0]       pmp_size,
  output logic [1:0]       pmp_prv,
  output logic             pmp_mprv,
  output logic [1:0]       pmp_mpp,
  input  logic             pmp_ok,
  input  logic             csr_wreq,
  output logic             csr_wack
);

  localparam logic [3:0] STARVE_MAX = 4'(starve_max);

  typedef enum logic [1:0] {RUN, DRAIN, CFG, SETTLE} state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       resp_pend;
  logic       resp_src;   // 1 = data, 0 = ifetch
  logic       gnt_en;

  // Grants only in RUN with no CSR write pending; gated by rst so that every
  // output reads 0 while reset is held, even with requests present.
  assign gnt_en = (state == RUN) & ~csr_wreq & ~rst;

  // Data wins ties until ifetch has lost starve_max cycles in a row.
  always_comb begin
    i_gnt = gnt_en & i_req & (~d_req | (starve_cnt == STARVE_MAX));
    d_gnt = gnt_en & d_req & ~i_gnt;
  end

  // Issue payload from the winner; all zero when nothing is granted.
  // Fetch checks are execute accesses (acc 00), size 0, and ignore MPRV.
  always_comb begin
    pmp_valid   = i_gnt | d_gnt;
    pmp_address = '0;
    pmp_acc     = 2'b00;
    pmp_size    = 2'b00;
    pmp_prv     = 2'b00;
    pmp_mprv    = 1'b0;
    pmp_mpp     = 2'b00;
    if (i_gnt) begin
      pmp_address = i_addr;
      pmp_prv     = prv;
      pmp_mpp     = mpp;
    end else if (d_gnt) begin
      pmp_address = d_addr;
      pmp_acc     = d_acc;
      pmp_size    = d_size;
      pmp_prv     = prv;
      pmp_mprv    = mprv;
      pmp_mpp     = mpp;
    end
  end

  // Route the PMP result back to whichever source issued the check.
  always_comb begin
    i_rvalid = resp_pend & ~resp_src;
    d_rvalid = resp_pend &  resp_src;
    i_ok     = pmp_ok & i_rvalid;
    d_ok     = pmp_ok & d_rvalid;
  end

  // Track the single in-flight check; reset discards it.
  always_ff @(posedge clk300p or posedge rst) begin
    if (rst) begin
      resp_pend <= 1'b0;
      resp_src  <= 1'b0;
    end else begin
      resp_pend <= pmp_valid;
      resp_src  <= d_gnt;
    end
  end

  // Count consecutive ifetch losses in RUN; frozen during a CSR sequence.
  always_ff @(posedge clk300p or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == RUN) begin
      if (!i_req || i_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // CSR sequencing state register.
  always_ff @(posedge clk300p or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // CSR sequencing: block grants, drain, acknowledge, settle one cycle.
  always_comb begin
    state_nxt = state;
    csr_wack  = 1'b0;
    case (state)
      RUN:    if (csr_wreq) state_nxt = DRAIN;
      DRAIN:  if (!resp_pend) state_nxt = CFG;
      CFG: begin
        csr_wack  = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Testbench for pmp_check_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (pending requests, loss streak,
// last winner).
module tb_pmp_check_arbiter;
  localparam int MSB = 55;
  localparam int SM  = 4;

  logic           clk300p = 1'b0;
  logic           rst;
  logic           i_req, d_req, mprv, pmp_ok, csr_wreq;
  logic [MSB:0]   i_addr, d_addr;
  logic [1:0]     d_acc, d_size, prv, mpp;
  logic           i_gnt, i_rvalid, i_ok, d_gnt, d_rvalid, d_ok;
  logic           pmp_valid, pmp_mprv, csr_wack;
  logic [MSB:0]   pmp_address;
  logic [1:0]     pmp_acc, pmp_size, pmp_prv, pmp_mpp;

  int total = 0;
  int bad   = 0;

  pmp_check_arbiter #(.pmp_msb(MSB), .starve_max(SM)) dut (
    .clk300p(clk300p), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_ok(i_ok),
    .d_req(d_req), .d_addr(d_addr), .d_acc(d_acc), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_ok(d_ok),
    .prv(prv), .mprv(mprv), .mpp(mpp),
    .pmp_valid(pmp_valid), .pmp_address(pmp_address), .pmp_acc(pmp_acc),
    .pmp_size(pmp_size), .pmp_prv(pmp_prv), .pmp_mprv(pmp_mprv), .pmp_mpp(pmp_mpp),
    .pmp_ok(pmp_ok), .csr_wreq(csr_wreq), .csr_wack(csr_wack)
  );

  always #5 clk300p = ~clk300p;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic nxt();
    @(posedge clk300p);
    #1;
  endtask

  task automatic idle();
    i_req = 0; d_req = 0; csr_wreq = 0; pmp_ok = 0;
    i_addr = '0; d_addr = '0; d_acc = 2'b01; d_size = 0;
    prv = 2'b11; mprv = 0; mpp = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    i_req = 1; d_req = 1; pmp_ok = 1; csr_wreq = 0;
    #2;
    total++;
    if ({i_gnt, d_gnt, pmp_valid, i_rvalid, d_rvalid, i_ok, d_ok, csr_wack} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000000",
        {i_gnt, d_gnt, pmp_valid, i_rvalid, d_rvalid, i_ok, d_ok, csr_wack});
    end
    total++;
    if ({pmp_address, pmp_acc, pmp_size, pmp_prv, pmp_mprv, pmp_mpp} !== '0) begin
      bad++; $display("FAIL reset_payload got=%h exp=0", pmp_address);
    end
    nxt(); nxt();
    idle(); rst = 0;
    nxt();
  endtask

  task automatic test_ifetch_single();
    idle(); nxt();
    i_req = 1; i_addr = 56'h0000_0000_8000_0000; prv = 2'b11; mprv = 1; mpp = 2'b01;
    #2;
    total++;
    if ({i_gnt, d_gnt, pmp_valid} !== 3'b101) begin
      bad++; $display("FAIL if_gnt got=%b exp=101", {i_gnt, d_gnt, pmp_valid});
    end
    total++;
    if (pmp_address !== 56'h80000000 || pmp_acc !== 2'b00 || pmp_mprv !== 1'b0 ||
        pmp_prv !== 2'b11 || pmp_mpp !== 2'b01 || pmp_size !== 2'b00) begin
      bad++; $display("FAIL if_payload got=%h/%b/%b/%b/%b exp=80000000/00/0/11/01",
        pmp_address, pmp_acc, pmp_mprv, pmp_prv, pmp_mpp);
    end
    nxt();
    i_req = 0; pmp_ok = 1;
    #2;
    total++;
    if ({i_rvalid, i_ok, d_rvalid, d_ok} !== 4'b1100) begin
      bad++; $display("FAIL if_resp got=%b exp=1100", {i_rvalid, i_ok, d_rvalid, d_ok});
    end
    nxt();
  endtask

  // Both sources held high: the grant pattern is SM data wins then one fetch.
  task automatic test_starve();
    logic prev_d, prev_v, exp_i;
    idle(); nxt(); nxt();
    prev_v = 0; prev_d = 0;
    i_req = 1; d_req = 1;
    for (int k = 0; k < 15; k++) begin
      pmp_ok = 1'($urandom_range(0, 1));
      #2;
      exp_i = ((k % (SM + 1)) == SM);
      total++;
      if ({i_gnt, d_gnt} !== {exp_i, ~exp_i}) begin
        bad++; $display("FAIL starve_gnt k=%0d got=%b exp=%b", k, {i_gnt, d_gnt}, {exp_i, ~exp_i});
      end
      if (k > 0) begin
        total++;
        if ({i_rvalid, d_rvalid, i_ok, d_ok} !==
            {prev_v & ~prev_d, prev_v & prev_d, prev_v & ~prev_d & pmp_ok, prev_v & prev_d & pmp_ok}) begin
          bad++; $display("FAIL starve_resp k=%0d got=%b exp_src_d=%b", k,
            {i_rvalid, d_rvalid, i_ok, d_ok}, prev_d);
        end
      end
      prev_v = 1; prev_d = ~exp_i;
      nxt();
    end
    idle(); nxt();
  endtask

  task automatic test_mprv();
    idle(); nxt();
    d_req = 1; d_acc = 2'b11; d_size = 2'b11; d_addr = 56'h00AB_CDEF_0123_4568;
    mprv = 1; mpp = 2'b00; prv = 2'b11;
    #2;
    total++;
    if ({d_gnt, pmp_valid, pmp_mprv, pmp_mpp, pmp_acc, pmp_size} !== 9'b1_1_1_00_11_11) begin
      bad++; $display("FAIL mprv_issue got=%b exp=111001111",
        {d_gnt, pmp_valid, pmp_mprv, pmp_mpp, pmp_acc, pmp_size});
    end
    total++;
    if (pmp_address !== 56'h00AB_CDEF_0123_4568) begin
      bad++; $display("FAIL mprv_addr got=%h exp=abcdef01234568", pmp_address);
    end
    nxt();
    d_req = 0; pmp_ok = 0;
    #2;
    total++;
    if ({d_rvalid, d_ok, i_rvalid} !== 3'b100) begin
      bad++; $display("FAIL mprv_resp got=%b exp=100", {d_rvalid, d_ok, i_rvalid});
    end
    nxt();
  endtask

  // Data granted at G, CSR write first seen at G+1: response still delivered,
  // DRAIN at G+2, wack at G+3, SETTLE at G+4, grants again at G+5.
  task automatic test_csr_after_grant();
    idle(); nxt();
    d_req = 1;
    #2;
    total++;
    if (d_gnt !== 1'b1) begin
      bad++; $display("FAIL csrg_gnt got=%b exp=1", d_gnt);
    end
    nxt();
    i_req = 1; csr_wreq = 1; pmp_ok = 1;
    for (int c = 1; c <= 5; c++) begin
      #2;
      if (c == 1) begin
        total++;
        if ({d_rvalid, d_ok} !== 2'b11) begin
          bad++; $display("FAIL csrg_resp got=%b exp=11", {d_rvalid, d_ok});
        end
      end
      total++;
      if (csr_wack !== (c == 3)) begin
        bad++; $display("FAIL csrg_wack c=%0d got=%b exp=%b", c, csr_wack, c == 3);
      end
      total++;
      if ((i_gnt | d_gnt | pmp_valid) !== (c == 5)) begin
        bad++; $display("FAIL csrg_block c=%0d got=%b exp=%b", c, i_gnt | d_gnt | pmp_valid, c == 5);
      end
      nxt();
      if (c == 3) csr_wreq = 0;
    end
    idle(); nxt();
  endtask

  task automatic test_reset_inflight();
    idle(); nxt();
    i_req = 1; i_addr = 56'h1000;
    #2;
    total++;
    if (i_gnt !== 1'b1) begin
      bad++; $display("FAIL rsti_gnt got=%b exp=1", i_gnt);
    end
    nxt();
    rst = 1; pmp_ok = 1;
    #2;
    total++;
    if ({i_gnt, pmp_valid, i_rvalid, i_ok, d_rvalid} !== 5'b0) begin
      bad++; $display("FAIL rsti_zero got=%b exp=00000", {i_gnt, pmp_valid, i_rvalid, i_ok, d_rvalid});
    end
    nxt();
    rst = 0; i_req = 0;
    #2;
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b00) begin
      bad++; $display("FAIL rsti_norv got=%b exp=00", {i_rvalid, d_rvalid});
    end
    nxt();
    i_req = 1;
    #2;
    total++;
    if (i_gnt !== 1'b1) begin
      bad++; $display("FAIL rsti_regnt got=%b exp=1", i_gnt);
    end
    nxt();
    i_req = 0;
    #2;
    total++;
    if ({i_rvalid, i_ok} !== 2'b11) begin
      bad++; $display("FAIL rsti_rv got=%b exp=11", {i_rvalid, i_ok});
    end
    nxt();
  endtask

  task automatic test_csr_idle();
    idle(); nxt();
    csr_wreq = 1;
    for (int c = 0; c <= 4; c++) begin
      #2;
      total++;
      if (csr_wack !== (c == 2)) begin
        bad++; $display("FAIL csri_wack c=%0d got=%b exp=%b", c, csr_wack, c == 2);
      end
      nxt();
      if (c == 2) csr_wreq = 0;
    end
    idle(); nxt();
  endtask

  // Random traffic against a transaction-level model: requests stay pending
  // until granted; fetch wins a tie only after SM consecutive losses.
  task automatic test_random();
    logic ip, dp;
    logic [MSB:0] ia, da;
    logic [1:0] dacc, dsz;
    int losses, prev_w, w;
    logic [MSB:0] e_addr;
    logic [1:0] e_acc, e_size, e_prv, e_mpp;
    logic e_mprv;
    idle(); nxt(); nxt();
    ip = 0; dp = 0; losses = 0; prev_w = 0;
    ia = '0; da = '0; dacc = 2'b01; dsz = 0;
    for (int k = 0; k < 400; k++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1; ia = MSB'({$urandom(), $urandom()});
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; da = MSB'({$urandom(), $urandom()});
        dacc = $urandom_range(0, 1) ? 2'b11 : 2'b01; dsz = 2'($urandom());
      end
      i_req = ip; i_addr = ia; d_req = dp; d_addr = da; d_acc = dacc; d_size = dsz;
      prv = 2'($urandom()); mpp = 2'($urandom()); mprv = 1'($urandom());
      pmp_ok = 1'($urandom());
      if (ip && dp) w = (losses == SM) ? 1 : 2;
      else if (ip)  w = 1;
      else if (dp)  w = 2;
      else          w = 0;
      e_addr = (w == 1) ? ia : (w == 2) ? da : '0;
      e_acc  = (w == 2) ? dacc : 2'b00;
      e_size = (w == 2) ? dsz : 2'b00;
      e_prv  = (w != 0) ? prv : 2'b00;
      e_mpp  = (w != 0) ? mpp : 2'b00;
      e_mprv = (w == 2) ? mprv : 1'b0;
      #2;
      total++;
      if ({i_gnt, d_gnt, pmp_valid} !== {w == 1, w == 2, w != 0}) begin
        bad++; $display("FAIL rnd_gnt k=%0d got=%b exp=%b", k, {i_gnt, d_gnt, pmp_valid},
          {w == 1, w == 2, w != 0});
      end
      total++;
      if ({pmp_address, pmp_acc, pmp_size, pmp_prv, pmp_mprv, pmp_mpp} !==
          {e_addr, e_acc, e_size, e_prv, e_mprv, e_mpp}) begin
        bad++; $display("FAIL rnd_payload k=%0d got=%h exp=%h", k,
          {pmp_address, pmp_acc, pmp_size, pmp_prv, pmp_mprv, pmp_mpp},
          {e_addr, e_acc, e_size, e_prv, e_mprv, e_mpp});
      end
      total++;
      if ({i_rvalid, i_ok, d_rvalid, d_ok} !==
          {prev_w == 1, (prev_w == 1) & pmp_ok, prev_w == 2, (prev_w == 2) & pmp_ok}) begin
        bad++; $display("FAIL rnd_resp k=%0d got=%b prev_winner=%0d ok=%b", k,
          {i_rvalid, i_ok, d_rvalid, d_ok}, prev_w, pmp_ok);
      end
      if (ip && w != 1) losses = (losses < SM) ? losses + 1 : SM;
      else              losses = 0;
      if (w == 1) ip = 0;
      if (w == 2) dp = 0;
      prev_w = w;
      nxt();
    end
    idle(); nxt();
  endtask

  initial begin
    test_reset();
    test_ifetch_single();
    test_starve();
    test_mprv();
    test_csr_after_grant();
    test_reset_inflight();
    test_csr_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
